// File: rtl/lsu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lsu_pkg : op encodings, FSM states and op legality check for LSU    |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package lsu_pkg;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    MERGE = 3'd2,
    WR    = 3'd3,
    RESP  = 3'd4
  } lsu_state_e;

  // Stores have no signedness, so the unsigned encodings are rejected for them.
  function automatic logic op_error(input logic store, input logic [2:0] op,
                                    input logic [1:0] offset);
    logic err;
    case (op)
      OP_B, OP_BU: err = 1'b0;
      OP_H, OP_HU: err = offset[0];
      OP_W:        err = (offset != 2'b00);
      default:     err = 1'b1;
    endcase
    if (store && op[2]) err = 1'b1;
    return err;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lsu_align : big-endian load extraction/extension and store merge    |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  offset,
  input  logic [31:0] mem_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [4:0]  shift;
  logic [31:0] lane_mask;
  logic [31:0] shifted;

  always_comb begin
    // Byte offset 0 sits in the top lane, so lower offsets shift further.
    case (op)
      OP_B, OP_BU: begin
        shift     = {~offset, 3'b000};
        lane_mask = 32'h0000_00FF;
      end
      OP_H, OP_HU: begin
        shift     = {~offset[1], 4'b0000};
        lane_mask = 32'h0000_FFFF;
      end
      default: begin
        shift     = 5'd0;
        lane_mask = 32'hFFFF_FFFF;
      end
    endcase

    shifted = mem_word >> shift;

    case (op)
      OP_B, OP_BU: load_data = op[2] ? {24'h0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
      OP_H, OP_HU: load_data = op[2] ? {16'h0, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
      default:     load_data = mem_word;
    endcase

    merged_word = (mem_word & ~(lane_mask << shift)) | ((wdata & lane_mask) << shift);
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | load_store_unit : single-outstanding LSU with read-modify-write     |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              memread,
  output logic              memwrite,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       writeData,
  input  logic [31:0]       data
);

  lsu_state_e        state_q, state_d;
  logic              store_q, store_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic [31:0]       merge_q, merge_d;
  logic [31:0]       load_data;
  logic [31:0]       merged_word;

  lsu_align u_align (
    .op          (op_q),
    .offset      (addr_q[1:0]),
    .mem_word    (data),
    .wdata       (merge_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_comb begin
    state_d = state_q;
    store_d = store_q;
    op_d    = op_q;
    addr_d  = addr_q;
    err_d   = err_q;
    merge_d = merge_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          store_d = req_store;
          op_d    = req_op;
          addr_d  = req_addr;
          merge_d = req_wdata;
          err_d   = op_error(req_store, req_op, req_addr[1:0]);
          if (err_d)                 state_d = RESP;
          else if (!req_store)       state_d = RD;
          else if (req_op == OP_W)   state_d = WR;
          else                       state_d = RD;
        end
      end
      RD:    state_d = store_q ? MERGE : RESP;
      MERGE: begin
        // merge_q held the store data; it now becomes the full word to write.
        merge_d = merged_word;
        state_d = WR;
      end
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      store_q <= 1'b0;
      op_q    <= 3'b000;
      addr_q  <= '0;
      err_q   <= 1'b0;
      merge_q <= 32'h0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      merge_q <= merge_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = (resp_valid && !store_q && !err_q) ? load_data : 32'h0;
  assign memread    = (state_q == RD);
  assign memwrite   = (state_q == WR);
  assign address    = {addr_q[ADDR_W-1:2], 2'b00};
  assign writeData  = memwrite ? merge_q : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_load_store_unit : randomized bench with a byte-array memory model|
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_load_store_unit;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_store = 1'b0;
  logic [2:0]        req_op = 3'b000;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = 32'h0;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              memread;
  logic              memwrite;
  logic [ADDR_W-1:0] address;
  logic [31:0]       writeData;
  logic [31:0]       mem_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] mb   [64];
  logic [7:0] refm [64];
  logic [5:0] wa;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .memread(memread), .memwrite(memwrite), .address(address),
    .writeData(writeData), .data(mem_data)
  );

  always #5 clk = ~clk;
  assign wa = address[5:0];

  // Data memory: byte array, big-endian word view, registered read.
  initial begin
    mem_data <= 32'h0;
    for (int i = 0; i < 64; i++) mb[i] <= 8'($urandom);
    mb[16] <= 8'h88; mb[17] <= 8'h99; mb[18] <= 8'hAA; mb[19] <= 8'hBB;
    forever begin
      @(posedge clk);
      if (memread) mem_data <= {mb[wa], mb[wa + 6'd1], mb[wa + 6'd2], mb[wa + 6'd3]};
      if (memwrite) begin
        mb[wa]        <= writeData[31:24];
        mb[wa + 6'd1] <= writeData[23:16];
        mb[wa + 6'd2] <= writeData[15:8];
        mb[wa + 6'd3] <= writeData[7:0];
      end
    end
  end

  function automatic int op_size(input logic [2:0] op);
    case (op)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit ref_illegal(input bit st, input logic [2:0] op, input int a);
    if (op_size(op) == 0) return 1'b1;
    if (st && op[2]) return 1'b1;
    return (a % op_size(op)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] op, input int a);
    int n = op_size(op);
    longint v = 0;
    for (int i = 0; i < n; i++) v = v * 256 + longint'(refm[a + i]);
    if (!op[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_word(input int a);
    int b = a - (a % 4);
    return {refm[b], refm[b + 1], refm[b + 2], refm[b + 3]};
  endfunction

  function automatic logic [31:0] mem_word(input int a);
    int b = a - (a % 4);
    return {mb[b], mb[b + 1], mb[b + 2], mb[b + 3]};
  endfunction

  task automatic ref_store(input int a, input int n, input logic [31:0] wd);
    for (int i = 0; i < n; i++) refm[a + i] = 8'((wd >> (8 * (n - 1 - i))) & 32'hFF);
  endtask

  // One request from an idle cycle through its response; returns at the RESP negedge.
  task automatic do_req(input bit st, input logic [2:0] op, input int a,
                        input logic [31:0] wd, input string tag, output logic [31:0] rdata_o);
    bit ill, got_err, busy_bad;
    int n, exp_lat, exp_rd, exp_wr, lat, rd_cnt, wr_cnt, rd_cyc, wr_cyc;
    logic [31:0] exp_rdata, got_rdata, got_wd;
    ill = ref_illegal(st, op, a);
    n = op_size(op);
    exp_rdata = 32'h0; exp_rd = -1; exp_wr = -1;
    if (ill)           exp_lat = 1;
    else if (!st)      begin exp_lat = 2; exp_rd = 1; exp_rdata = ref_load(op, a); end
    else if (n == 4)   begin exp_lat = 2; exp_wr = 1; end
    else               begin exp_lat = 4; exp_rd = 1; exp_wr = 3; end
    if (st && !ill) ref_store(a, n, wd);

    @(negedge clk);
    req_valid = 1'b1; req_store = st; req_op = op; req_addr = 32'(a); req_wdata = wd;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s ready_idle: got %b want 1", tag, req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0; req_wdata = $urandom;
    lat = 0; rd_cnt = 0; wr_cnt = 0; rd_cyc = -1; wr_cyc = -1; busy_bad = 1'b0;
    got_rdata = 32'h0; got_wd = 32'h0; got_err = 1'b0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      if (c > 1) @(negedge clk);
      if (memread)  begin rd_cnt++; rd_cyc = c; end
      if (memwrite) begin wr_cnt++; wr_cyc = c; got_wd = writeData; end
      if (req_ready !== 1'b0 || (memread && memwrite)) busy_bad = 1'b1;
      if (resp_valid === 1'b1) begin lat = c; got_rdata = resp_rdata; got_err = resp_err; end
      else if (resp_rdata !== 32'h0) busy_bad = 1'b1;
    end

    checks++;
    if (lat != exp_lat) begin
      errors++; $display("FAIL %s latency: got %0d want %0d", tag, lat, exp_lat);
    end
    checks++;
    if (rd_cnt != (exp_rd > 0 ? 1 : 0) || rd_cyc != exp_rd) begin
      errors++; $display("FAIL %s memread: got %0d pulses at cycle %0d want cycle %0d", tag, rd_cnt, rd_cyc, exp_rd);
    end
    checks++;
    if (wr_cnt != (exp_wr > 0 ? 1 : 0) || wr_cyc != exp_wr) begin
      errors++; $display("FAIL %s memwrite: got %0d pulses at cycle %0d want cycle %0d", tag, wr_cnt, wr_cyc, exp_wr);
    end
    if (exp_wr > 0) begin
      checks++;
      if (got_wd !== ref_word(a)) begin
        errors++; $display("FAIL %s writeData: got %h want %h", tag, got_wd, ref_word(a));
      end
    end
    checks++;
    if (got_rdata !== exp_rdata) begin
      errors++; $display("FAIL %s rdata: got %h want %h", tag, got_rdata, exp_rdata);
    end
    checks++;
    if (got_err !== ill) begin
      errors++; $display("FAIL %s err: got %b want %b", tag, got_err, ill);
    end
    checks++;
    if (busy_bad) begin
      errors++; $display("FAIL %s busy_outputs: got bad ready/rdata/strobes want clean", tag);
    end
    checks++;
    if (mem_word(a) !== ref_word(a)) begin
      errors++; $display("FAIL %s memory: got %h want %h", tag, mem_word(a), ref_word(a));
    end
    rdata_o = got_rdata;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 64; i++) refm[i] = mb[i];
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_err, memread, memwrite} !== 5'b10000) begin
      errors++; $display("FAIL reset_ctrl: got %b want 10000", {req_ready, resp_valid, resp_err, memread, memwrite});
    end
    checks++;
    if (resp_rdata !== 32'h0 || writeData !== 32'h0) begin
      errors++; $display("FAIL reset_data: got rdata %h wdata %h want 0", resp_rdata, writeData);
    end
    checks++;
    if (address !== '0) begin
      errors++; $display("FAIL reset_address: got %h want 0", address);
    end
  endtask

  task automatic test_directed_loads();
    logic [31:0] r;
    do_req(1'b0, 3'b000, 32'h11, 32'h0, "ld_b_11", r);
    checks++;
    if (r !== 32'hFFFFFF99) begin errors++; $display("FAIL ld_b_11 value: got %h want ffffff99", r); end
    do_req(1'b0, 3'b101, 32'h12, 32'h0, "ld_hu_12", r);
    checks++;
    if (r !== 32'h0000AABB) begin errors++; $display("FAIL ld_hu_12 value: got %h want 0000aabb", r); end
    do_req(1'b0, 3'b001, 32'h12, 32'h0, "ld_h_12", r);
    checks++;
    if (r !== 32'hFFFFAABB) begin errors++; $display("FAIL ld_h_12 value: got %h want ffffaabb", r); end
    do_req(1'b0, 3'b010, 32'h0E, 32'h0, "ld_w_0e_misaligned", r);
  endtask

  task automatic test_reset_mid_write();
    bit saw_resp;
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_op = 3'b010; req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (memwrite !== 1'b1) begin errors++; $display("FAIL rst_wr pre_write: got memwrite %b want 1", memwrite); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (memwrite !== 1'b0) begin errors++; $display("FAIL rst_wr edge: got memwrite %b want 0", memwrite); end
    @(negedge clk);
    reset = 1'b0;
    saw_resp = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) saw_resp = 1'b1;
    end
    checks++;
    if (mem_word(32'h10) !== 32'h8899AABB) begin
      errors++; $display("FAIL rst_wr memory: got %h want 8899aabb", mem_word(32'h10));
    end
    checks++;
    if (saw_resp) begin errors++; $display("FAIL rst_wr resp: got resp_valid want none"); end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_wr ready: got %b want 1", req_ready); end
  endtask

  task automatic test_directed_store();
    logic [31:0] r;
    do_req(1'b1, 3'b000, 32'h13, 32'h12345677, "st_b_13", r);
    checks++;
    if (mem_word(32'h10) !== 32'h8899AA77) begin
      errors++; $display("FAIL st_b_13 word: got %h want 8899aa77", mem_word(32'h10));
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] rdy, rsp, mrd;
    logic [31:0] exp1, exp2, got1, got2;
    exp1 = ref_load(3'b010, 32'h20);
    exp2 = ref_load(3'b100, 32'h25);
    rdy = '0; rsp = '0; mrd = '0; got1 = 32'h0; got2 = 32'h0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c == 0) begin req_valid = 1'b1; req_store = 1'b0; req_op = 3'b010; req_addr = 32'h20; end
      if (c == 1) begin req_op = 3'b100; req_addr = 32'h25; end
      if (c == 4) req_valid = 1'b0;
      rdy[c] = req_ready; rsp[c] = resp_valid; mrd[c] = memread;
      if (c == 2) got1 = resp_rdata;
      if (c == 5) got2 = resp_rdata;
    end
    checks++;
    if (rdy !== 7'b1001001) begin errors++; $display("FAIL b2b ready: got %b want 1001001", rdy); end
    checks++;
    if (rsp !== 7'b0100100) begin errors++; $display("FAIL b2b resp: got %b want 0100100", rsp); end
    checks++;
    if (mrd !== 7'b0010010) begin errors++; $display("FAIL b2b memread: got %b want 0010010", mrd); end
    checks++;
    if (got1 !== exp1 || got2 !== exp2) begin
      errors++; $display("FAIL b2b data: got %h %h want %h %h", got1, got2, exp1, exp2);
    end
  endtask

  task automatic test_random();
    logic [31:0] r;
    bit st;
    logic [2:0] op;
    int a, n;
    for (int i = 0; i < 40; i++) begin
      st = 1'($urandom_range(0, 1));
      op = 3'($urandom_range(0, 7));
      a  = $urandom_range(0, 63);
      n  = op_size(op);
      if (n != 0 && $urandom_range(0, 3) != 0) a = a - (a % n);
      do_req(st, op, a, $urandom, $sformatf("rand%0d", i), r);
    end
  endtask

  initial begin
    test_reset();
    test_directed_loads();
    test_reset_mid_write();
    test_directed_store();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width on both core and memory sides.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  core presents a load/store request.
REQ-005 req_ready  output  1  unit accepts a request this cycle; high only in IDLE.
REQ-006 req_store  input  1  1 = store, 0 = load.
REQ-007 req_op  input  3  size/sign code: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned.
REQ-008 req_addr  input  ADDR_W  byte address.
REQ-009 req_wdata  input  32  store data, right-justified.
REQ-010 resp_valid  output  1  one-cycle completion pulse, no backpressure.
REQ-011 resp_rdata  output  32  extended load result, valid with resp_valid, 0 otherwise.
REQ-012 resp_err  output  1  misaligned or illegal op, valid with resp_valid.
REQ-013 memread  output  1  read strobe to data memory.
REQ-014 memwrite  output  1  write strobe to data memory.
REQ-015 address  output  ADDR_W  word-aligned memory address {req_addr[ADDR_W-1:2],2'b00}.
REQ-016 writeData  output  32  full word written to memory.
REQ-017 data  input  32  memory read word, registered by memory on the clk edge where memread is high, held until the next read.

Function
REQ-018 Memory word SHALL be big-endian: byte offset 0 = bits [31:24], offset 3 = bits [7:0].
REQ-019 Acceptance SHALL occur on an edge where req_valid and req_ready are both high; req_store, req_op, req_addr, req_wdata SHALL be latched then.
REQ-020 FSM states SHALL be IDLE, RD, MERGE, WR, RESP.
REQ-021 Error check at acceptance: half with addr[0]=1, word with addr[1:0]!=0, or op in {011,110,111}, or store with op[2]=1 -> IDLE->RESP with resp_err=1, no memread/memwrite.
REQ-022 Load: IDLE->RD (memread=1)->RESP; resp_valid in cycle 2 after acceptance cycle 0.
REQ-023 Word store: IDLE->WR (memwrite=1, writeData=wdata)->RESP; resp_valid in cycle 2.
REQ-024 Byte/half store: IDLE->RD->MERGE (merge latched wdata lane into data, register result)->WR->RESP; resp_valid in cycle 4; exactly one memwrite pulse.
REQ-025 Load extraction: byte/half selected by addr[1:0]; op[2]=0 sign-extends, op[2]=1 zero-extends; word passes through.
REQ-026 RESP SHALL always return to IDLE; next acceptance no earlier than the cycle after RESP.
REQ-027 memread high only in RD, memwrite high only in WR, both decoded from registered state; never both high.
REQ-028 address and writeData SHALL hold stable from RD/WR entry until RESP; writeData=0 outside WR.
REQ-029 req_valid while busy SHALL be ignored (req_ready=0), not queued.

Reset
REQ-030 reset SHALL force IDLE immediately, regardless of state, including mid-RMW.
REQ-031 Reset values: req_ready=1 (once reset released), resp_valid=0, resp_rdata=0, resp_err=0, memread=0, memwrite=0, address=0, writeData=0, latched request and merge registers 0.
REQ-032 Reset asserted before the WR edge SHALL prevent any memory write; no partial response after reset.

Structure
REQ-033 Package lsu_pkg SHALL hold op encodings (OP_B, OP_H, OP_W, OP_BU, OP_HU) and the FSM state enum.
REQ-034 One combinational sub-module lsu_align SHALL perform load extraction/extension and store lane merge; FSM and registers stay in load_store_unit.

Verification (memory word at 0x10 preloaded 0x8899AABB)
REQ-035 Load op=000 addr=0x11 -> memread pulse cycle 1, resp_valid cycle 2, resp_rdata=0xFFFFFF99, resp_err=0.
REQ-036 Load op=101 addr=0x12 -> 0x0000AABB; op=001 addr=0x12 -> 0xFFFFAABB.
REQ-037 Store op=000 addr=0x13 wdata=0x12345677 -> memread cycle 1, memwrite cycle 3 with writeData=0x8899AA77, resp_valid cycle 4; memory word 0x8899AA77.
REQ-038 Load op=010 addr=0x0E -> resp_valid+resp_err=1 cycle 1, resp_rdata=0, memread/memwrite never high.
REQ-039 Store op=010 addr=0x10 wdata=0xDEADBEEF, reset pulsed in cycle 1 -> memwrite not seen at edge, memory still 0x8899AABB, no resp_valid, req_ready=1 after release.
REQ-040 req_valid held high across two loads -> req_ready low cycles 1-2, second acceptance cycle 3, two resp_valid pulses, no lost or duplicated access.
